// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store, one transaction in flight, with a per-transaction ack timeout.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} src_t;

  state_t          state, state_nxt;
  src_t            owner, owner_nxt;
  src_t            last_grant, last_nxt;
  src_t            pick;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   rd;

  logic            mem_req_nxt, mem_we_nxt;
  logic [BW-1:0]   mem_be_nxt;
  logic [AW-1:0]   mem_addr_nxt;
  logic [DW-1:0]   mem_wdata_nxt;
  logic            if_gnt_nxt, if_done_nxt, if_err_nxt;
  logic            dm_gnt_nxt, dm_done_nxt, dm_err_nxt;
  logic [DW-1:0]   if_rdata_nxt, dm_rdata_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= FETCH;
      last_grant <= FETCH;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_done    <= 1'b0;
      dm_err     <= 1'b0;
      dm_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_be     <= mem_be_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_gnt     <= if_gnt_nxt;
      if_done    <= if_done_nxt;
      if_err     <= if_err_nxt;
      if_rdata   <= if_rdata_nxt;
      dm_gnt     <= dm_gnt_nxt;
      dm_done    <= dm_done_nxt;
      dm_err     <= dm_err_nxt;
      dm_rdata   <= dm_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last_grant;
    cnt_nxt       = cnt;
    pick          = FETCH;
    rd            = '0;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_be_nxt    = mem_be;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_gnt_nxt    = 1'b0;
    if_done_nxt   = 1'b0;
    if_err_nxt    = 1'b0;
    if_rdata_nxt  = if_rdata;
    dm_gnt_nxt    = 1'b0;
    dm_done_nxt   = 1'b0;
    dm_err_nxt    = 1'b0;
    dm_rdata_nxt  = dm_rdata;

    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          // On conflict the side that did not win last time goes first.
          pick        = (dm_req && (!if_req || last_grant == FETCH)) ? DATA : FETCH;
          owner_nxt   = pick;
          last_nxt    = pick;
          cnt_nxt     = CW'(1);
          mem_req_nxt = 1'b1;
          state_nxt   = BUSY;
          if (pick == DATA) begin
            mem_we_nxt    = dm_we;
            mem_be_nxt    = dm_be;
            mem_addr_nxt  = dm_addr;
            mem_wdata_nxt = dm_we ? dm_wdata : '0;
            dm_gnt_nxt    = 1'b1;
          end else begin
            mem_we_nxt    = 1'b0;
            mem_be_nxt    = '1;
            mem_addr_nxt  = if_addr;
            mem_wdata_nxt = '0;
            if_gnt_nxt    = 1'b1;
          end
        end
      end
      BUSY: begin
        // An ack in the final allowed cycle still counts as a normal completion.
        if (mem_ack || cnt == TMAX) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          cnt_nxt     = '0;
          rd          = (mem_ack && !mem_we) ? mem_rdata : '0;
          if (owner == DATA) begin
            dm_done_nxt  = 1'b1;
            dm_err_nxt   = !mem_ack;
            dm_rdata_nxt = rd;
          end else begin
            if_done_nxt  = 1'b1;
            if_err_nxt   = !mem_ack;
            if_rdata_nxt = rd;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
